serial_byte_tx: RTL and testbench

//  Parallel-in / serial-out transmitter: the read-out end of the 8-bit register path.

---
 rtl/serial_byte_tx_pkg.sv | 21 ++
 rtl/serial_byte_tx_baud_tick_gen.sv | 38 +++
 rtl/serial_byte_tx.sv | 101 ++++++++++
 tb/tb_serial_byte_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_byte_tx_pkg.sv
// rtl/serial_byte_tx_pkg.sv - shared state encoding, line levels and sizing helper for serial_byte_tx
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_byte_tx_baud_tick_gen.sv
// rtl/serial_byte_tx_baud_tick_gen.sv - DIV-cycle bit timer; tick marks the last cycle of each serial bit
module baud_tick_gen
    import tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_div1
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, restart};
            assign tick = 1'b1;
        end else begin : g_divn
            localparam int CW = cnt_width(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (restart || cnt == LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign tick = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - parallel-in/serial-out frame transmitter: start, LSB-first data, optional even parity, stop
module serial_byte_tx
    import tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [BCW-1:0]   bit_cnt;
    logic             parity_q;
    logic             tick;
    logic             accept;
    logic             tx_d;

    assign accept = load && ready;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA:    if (tick && bit_cnt == LAST_BIT)
                         state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_nxt = STOP;
            // The last stop cycle doubles as the idle cycle so a waiting load starts the next frame gap-free.
            STOP:    if (tick) state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == IDLE) || (state == STOP && tick);
        busy    = ~ready;
        done    = (state == STOP) && tick;
        shift_d = shift_q;
        if (accept) begin
            shift_d = data_in;
        end else if (state == DATA && tick) begin
            shift_d = shift_q >> 1;
        end
        // tx is registered from the upcoming state so the line changes on the same edge as the FSM.
        case (state_nxt)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_q;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            tx       <= TX_IDLE;
        end else begin
            shift_q <= shift_d;
            tx      <= tx_d;
            if (accept) begin
                bit_cnt  <= '0;
                parity_q <= (PARITY_EN != 0) ? ^data_in : 1'b0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb/tb_serial_byte_tx.sv - scoreboard bench for serial_byte_tx with and without parity
module tb_serial_byte_tx;

    localparam int DIV = 4;

    typedef struct {
        int          start;
        logic [15:0] bits;
        int          nb;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] load = 2'b00;
    logic [1:0] ready;
    logic [1:0] busy;
    logic [1:0] tx;
    logic [1:0] done;
    logic [7:0] din [2];

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     free_at [2];
    frame_t q0 [$];
    frame_t q1 [$];
    frame_t cur [2];
    bit     act [2];

    always #5 clk = ~clk;

    serial_byte_tx #(.WIDTH(8), .DIV(DIV), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .data_in(din[0]), .load(load[0]),
        .ready(ready[0]), .busy(busy[0]), .tx(tx[0]), .done(done[0])
    );

    serial_byte_tx #(.WIDTH(8), .DIV(DIV), .PARITY_EN(0)) dut_n (
        .clk(clk), .rst(rst), .data_in(din[1]), .load(load[1]),
        .ready(ready[1]), .busy(busy[1]), .tx(tx[1]), .done(done[1])
    );

    function automatic frame_t mk(input logic [7:0] d, input bit par, input int start);
        frame_t f;
        f.start   = start;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) f.bits[k + 1] = d[k];
        f.nb = par ? 11 : 10;
        if (par) f.bits[9] = (($countones(d) % 2) == 1);
        f.bits[f.nb - 1] = 1'b1;
        return f;
    endfunction

    // Reference model of acceptance: a word is taken whenever load is high and the previous frame has reached its final cycle.
    always @(posedge clk) begin
        frame_t f;
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int g = 0; g < 2; g++) free_at[g] = cyc + 1;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (load[g] && cyc >= free_at[g]) begin
                    f = mk(din[g], g == 0, cyc + 1);
                    if (g == 0) q0.push_back(f);
                    else        q1.push_back(f);
                    free_at[g] = cyc + f.nb * DIV;
                end
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, g, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        logic   exp_tx;
        logic   exp_done;
        logic   exp_rdy;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                chk("rst_tx", g, 32'(tx[g]), 32'd1);
                chk("rst_ready", g, 32'(ready[g]), 32'd1);
                chk("rst_busy", g, 32'(busy[g]), 32'd0);
                chk("rst_done", g, 32'(done[g]), 32'd0);
                act[g] = 1'b0;
            end else begin
                if (!act[g] && ((g == 0) ? q0.size() : q1.size()) > 0) begin
                    f = (g == 0) ? q0.pop_front() : q1.pop_front();
                    chk("frame_start", g, 32'(f.start), 32'(cyc));
                    cur[g] = f;
                    act[g] = 1'b1;
                end
                exp_tx   = act[g] ? cur[g].bits[(cyc - cur[g].start) / DIV] : 1'b1;
                exp_done = act[g] && (cyc == cur[g].start + cur[g].nb * DIV - 1);
                exp_rdy  = (cyc >= free_at[g]);
                chk("tx", g, 32'(tx[g]), 32'(exp_tx));
                chk("done", g, 32'(done[g]), 32'(exp_done));
                chk("ready", g, 32'(ready[g]), 32'(exp_rdy));
                chk("busy", g, 32'(busy[g]), 32'(!exp_rdy));
                if (exp_done) act[g] = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            load = 2'b00;
        end
    endtask

    task automatic send(input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk);
        #1;
        din[0] = d0;
        din[1] = d1;
        load   = 2'b11;
        @(posedge clk);
        #1;
        load   = 2'b00;
        din[0] = $urandom_range(0, 255);
        din[1] = $urandom_range(0, 255);
    endtask

    initial begin
        din[0] = 8'h00;
        din[1] = 8'h00;
        act[0] = 1'b0;
        act[1] = 1'b0;
        free_at[0] = 0;
        free_at[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        send(8'hA5, 8'hA5);
        idle(50);
        send(8'h07, 8'h07);
        idle(50);

        // A second load mid-frame must be dropped.
        send(8'hA5, 8'hA5);
        idle(18);
        send(8'h3C, 8'h3C);
        idle(40);

        // Held load: the next word enters in the done cycle, with data changing right after acceptance.
        @(posedge clk);
        #1;
        din[0] = 8'h01;
        din[1] = 8'h01;
        load   = 2'b11;
        @(posedge clk);
        #1;
        din[0] = 8'hFF;
        din[1] = 8'hFF;
        repeat (60) @(posedge clk);
        #1 load = 2'b00;
        idle(50);

        // Reset while DATA bit 3 is on the line, asserted between edges.
        send(8'hC3, 8'hC3);
        idle(16);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        send(8'h55, 8'h55);
        idle(50);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                load[g] = ($urandom_range(0, 7) == 0);
                din[g]  = $urandom_range(0, 255);
            end
        end
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
